// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the byte-lane data memory.
// Holds request size codes, the INIT/RUN state enum and the default data window base.
// No ports; imported by dmem_lane_align and dmem_bytelane.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane steering for stores and lane extract + extension for loads.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: i_size/i_lane select the access; i_wdata -> o_be/o_wdata_rep (store path);
//        i_word/i_unsigned -> o_rdata (load path). Reserved size gives be=0, rdata=0.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;
  logic [15:0] w_half;

  // Store path: replicate the low byte/half across the word so each lane
  // already carries the right data; the byte enables pick the lanes.
  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_lane;
        o_wdata_rep = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be        = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
      end
      default: begin
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
      end
    endcase
  end

  // Load path: bring the addressed byte down to bit 0, then extend.
  assign w_shifted = i_word >> {i_lane, 3'b000};
  assign w_half    = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_rdata = 32'h0;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_rdata = i_word;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressable data RAM with byte/half/word lanes, load extension,
// alignment/range error check and a post-reset clear engine (INIT lasts DEPTH_WORDS cycles).
// Latency: response registered, rsp_valid one cycle after accept; full throughput, no rsp backpressure.
// Ports: clk/rst (async, active-high); req_* valid/ready request; rsp_valid/rsp_rdata/rsp_err
//        response; init_busy high while clearing; dbg_word0 is a live view of word 0.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR_DEFAULT,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy,
  output logic [31:0] dbg_word0
);

  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_BITS-1:0]   r_clr_ptr;
  logic [31:0]            r_mem [DEPTH_WORDS];
  logic                   r_rsp_valid;
  logic [31:0]            r_rsp_rdata;
  logic                   r_rsp_err;

  logic                   w_req_ready;
  logic                   w_init_busy;
  logic                   w_ptr_last;
  logic [31:0]            w_offset;
  logic [ADDR_BITS-1:0]   w_idx;
  logic [1:0]             w_lane;
  logic                   w_oor;
  logic                   w_misalign;
  logic                   w_err;
  logic                   w_acc;
  logic [3:0]             w_st_be;
  logic [31:0]            w_st_data;
  logic [31:0]            w_ld_data;
  logic [3:0]             w_mem_be;
  logic [ADDR_BITS-1:0]   w_mem_idx;
  logic [31:0]            w_mem_wdat;

  // ---------------- clear FSM ----------------
  assign w_ptr_last = (r_clr_ptr == ADDR_BITS'(DEPTH_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_init_busy = 1'b0;
    case (r_state)
      INIT: begin
        w_init_busy = 1'b1;
        // Without clearing, INIT still lasts one cycle so ready has a clean rise.
        if (!CLEAR_ON_RST || w_ptr_last) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_req_ready = 1'b1;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_ptr <= '0;
    end else if (r_state == INIT) begin
      r_clr_ptr <= r_clr_ptr + ADDR_BITS'(1);
    end
  end

  // ---------------- request decode ----------------
  // Subtracting the base with 32-bit wrap turns addresses below the window
  // into huge offsets, so a single upper-bits test covers both range ends.
  assign w_offset   = req_addr - BASE_ADDR;
  assign w_idx      = w_offset[ADDR_BITS+1:2];
  assign w_lane     = w_offset[1:0];
  assign w_oor      = (w_offset[31:ADDR_BITS+2] != '0);
  assign w_misalign = ((req_size == SZ_HALF) && w_lane[0])
                    | ((req_size == SZ_WORD) && (w_lane != 2'b00))
                    |  (req_size == SZ_RSVD);
  assign w_err      = w_oor | w_misalign;
  assign w_acc      = req_valid & w_req_ready;

  dmem_lane_align u_align (
    .i_size      (req_size),
    .i_lane      (w_lane),
    .i_unsigned  (req_unsigned),
    .i_wdata     (req_wdata),
    .i_word      (r_mem[w_idx]),
    .o_be        (w_st_be),
    .o_wdata_rep (w_st_data),
    .o_rdata     (w_ld_data)
  );

  // ---------------- array write port ----------------
  // One write port shared by the clear engine and stores; they never
  // overlap because req_ready is low for the whole of INIT.
  always_comb begin
    w_mem_be   = 4'b0000;
    w_mem_idx  = w_idx;
    w_mem_wdat = w_st_data;
    if ((r_state == INIT) && CLEAR_ON_RST) begin
      w_mem_be   = 4'b1111;
      w_mem_idx  = r_clr_ptr;
      w_mem_wdat = 32'h0;
    end else if (w_acc && req_we && !w_err) begin
      w_mem_be   = w_st_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_be[b]) begin
        r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdat[8*b +: 8];
      end
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_acc;
      r_rsp_err   <= w_acc & w_err;
      r_rsp_rdata <= (w_acc && !req_we && !w_err) ? w_ld_data : 32'h0;
    end
  end

  assign req_ready = w_req_ready;
  assign init_busy = w_init_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign dbg_word0 = r_mem[0];

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;
  logic [31:0] dbg_word0;

  int n_checks;
  int n_errs;

  dmem_bytelane #(
    .DEPTH_WORDS  (256),
    .BASE_ADDR    (32'h1001_0000),
    .CLEAR_ON_RST (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_busy    (init_busy),
    .dbg_word0    (dbg_word0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with rst low; returns at the first negedge where init_busy is low.
  task automatic wait_init(output int n_busy, output int n_rdy, output int n_rsp);
    n_busy = 0;
    n_rdy  = 0;
    n_rsp  = 0;
    while (init_busy === 1'b1 && n_busy < 2000) begin
      n_busy++;
      if (req_ready !== 1'b0) n_rdy++;
      if (rsp_valid !== 1'b0) n_rsp++;
      @(negedge clk);
    end
  endtask

  // Drive one request at a negedge; returns at the next negedge with the response visible.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic ld_chk(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
    txn(1'b0, sz, uns, addr, 32'h0);
    chk({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, "_dat"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_e});
  endtask

  task automatic st_chk(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_e);
    txn(1'b1, sz, 1'b0, addr, wd);
    chk({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, "_dat"}, rsp_rdata, 32'h0);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_e});
  endtask

  initial begin
    int nb, nr, ns;
    n_checks     = 0;
    n_errs       = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rvld",  {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_rerr",  {31'h0, rsp_err}, 32'h0);
    chk("rst_busy",  {31'h0, init_busy}, 32'h1);

    // A load held valid through INIT must be ignored until ready rises.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_WORD;
    req_addr  = 32'h1001_0000;
    rst       = 1'b0;
    wait_init(nb, nr, ns);
    req_valid = 1'b0;
    chk("init_len",      nb, 256);
    chk("init_no_ready", nr, 0);
    chk("init_no_rsp",   ns, 0);
    chk("ready_after",   {31'h0, req_ready}, 32'h1);

    ld_chk("clr_w0",   SZ_WORD, 1'b0, 32'h1001_0000, 32'h0, 1'b0);
    ld_chk("clr_wlast", SZ_WORD, 1'b0, 32'h1001_03FC, 32'h0, 1'b0);

    // Lanes and extension.
    st_chk("sw_beef", SZ_WORD, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0);
    ld_chk("lb7",  SZ_BYTE, 1'b0, 32'h1001_0007, 32'hFFFF_FFDE, 1'b0);
    ld_chk("lbu7", SZ_BYTE, 1'b1, 32'h1001_0007, 32'h0000_00DE, 1'b0);
    ld_chk("lh4",  SZ_HALF, 1'b0, 32'h1001_0004, 32'hFFFF_BEEF, 1'b0);
    ld_chk("lhu6", SZ_HALF, 1'b1, 32'h1001_0006, 32'h0000_DEAD, 1'b0);

    st_chk("sb5", SZ_BYTE, 32'h1001_0005, 32'hAABB_CC12, 1'b0);
    ld_chk("lw4_sb", SZ_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_12EF, 1'b0);
    ld_chk("lw0_keep", SZ_WORD, 1'b0, 32'h1001_0000, 32'h0, 1'b0);
    ld_chk("lw8_keep", SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 1'b0);

    st_chk("shA", SZ_HALF, 32'h1001_000A, 32'hFFFF_5678, 1'b0);
    ld_chk("lw8_sh", SZ_WORD, 1'b0, 32'h1001_0008, 32'h5678_0000, 1'b0);
    ld_chk("lhA",    SZ_HALF, 1'b0, 32'h1001_000A, 32'h0000_5678, 1'b0);
    ld_chk("lb9",    SZ_BYTE, 1'b0, 32'h1001_0009, 32'h0000_0000, 1'b0);

    // Word 0 visible on dbg_word0.
    st_chk("sw_w0", SZ_WORD, 32'h1001_0000, 32'hCAFE_F00D, 1'b0);
    chk("dbg_w0", dbg_word0, 32'hCAFE_F00D);

    // Error cases: no write, rdata forced to 0.
    ld_chk("lw_mis2", SZ_WORD, 1'b0, 32'h1001_0002, 32'h0, 1'b1);
    ld_chk("lw_mis6", SZ_WORD, 1'b0, 32'h1001_0006, 32'h0, 1'b1);
    ld_chk("lh_mis5", SZ_HALF, 1'b0, 32'h1001_0005, 32'h0, 1'b1);
    st_chk("sh_mis1", SZ_HALF, 32'h1001_0001, 32'h0000_1234, 1'b1);
    chk("dbg_after_sh_mis", dbg_word0, 32'hCAFE_F00D);
    ld_chk("ld_below", SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0, 1'b1);
    ld_chk("ld_above", SZ_WORD, 1'b0, 32'h1001_0400, 32'h0, 1'b1);
    st_chk("st_above", SZ_WORD, 32'h1001_0400, 32'h5555_5555, 1'b1);
    chk("dbg_after_oor", dbg_word0, 32'hCAFE_F00D);
    ld_chk("ld_rsvd", SZ_RSVD, 1'b0, 32'h1001_0004, 32'h0, 1'b1);
    st_chk("st_rsvd", SZ_RSVD, 32'h1001_0004, 32'h0, 1'b1);
    ld_chk("lw4_after_err", SZ_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_12EF, 1'b0);

    // Back-to-back store then load of the same word.
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h1001_0010;
    req_wdata    = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_vld1", {31'h0, rsp_valid}, 32'h1);
    req_we    = 1'b0;
    req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_vld2", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_dat2", rsp_rdata, 32'h1122_3344);
    @(negedge clk);
    chk("b2b_idle", {31'h0, rsp_valid}, 32'h0);

    // Reset with a load in flight: response must vanish at once.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_WORD;
    req_addr  = 32'h1001_0004;
    @(posedge clk);
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rrun_rvld",  {31'h0, rsp_valid}, 32'h0);
    chk("rrun_rdata", rsp_rdata, 32'h0);
    chk("rrun_busy",  {31'h0, init_busy}, 32'h1);
    chk("rrun_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset again 100 cycles into INIT; the clear must restart in full.
    repeat (100) @(negedge clk);
    chk("rinit_busy_pre", {31'h0, init_busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rinit_busy", {31'h0, init_busy}, 32'h1);
    chk("rinit_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_init(nb, nr, ns);
    chk("reinit_len",      nb, 256);
    chk("reinit_no_ready", nr, 0);
    chk("reinit_ready",    {31'h0, req_ready}, 32'h1);
    chk("reinit_dbg",      dbg_word0, 32'h0);
    ld_chk("reinit_w1", SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 1'b0);
    ld_chk("reinit_w4", SZ_WORD, 1'b0, 32'h1001_0010, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised, byte-addressable data memory for the MIPS core. Replaces the word-only store path with true byte and halfword lanes (little-endian), and does load sign/zero extension internally.
- Adds a valid/ready request interface, a 1-cycle registered response, alignment/range error detection, and a sequential post-reset clear engine.
- Sits between the core's MEM stage and the data RAM array; it is the only owner of the data address window.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h1001_0000, byte address of word 0; must be 4-aligned.
- CLEAR_ON_RST, 1, 1 = zero the whole array after reset; 0 = skip the clear (INIT lasts 1 cycle).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from the low bits.
- rsp_valid  out  1  one-cycle pulse, response for the request accepted in the previous cycle.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or had a reserved size.
- init_busy  out  1  clear engine running.
- dbg_word0  out  32  combinational view of array word 0.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1, clear pointer=0, state=INIT.
- States: INIT -> RUN.
  - INIT: writes word[ptr]=0 and increments ptr each cycle. Leaves INIT the cycle after ptr == DEPTH_WORDS-1, so INIT lasts DEPTH_WORDS cycles (1 cycle if CLEAR_ON_RST=0).
  - RUN: req_ready=1 and init_busy=0. The block stays in RUN until the next rst.
- Reset mid-INIT or mid-RUN: immediate return to the reset values. The clear restarts from word 0. Any in-flight response is dropped (rsp_valid=0).
- Accept condition: req_valid && req_ready at edge T. The response appears in the cycle after edge T (rsp_valid=1 for exactly one cycle). Full throughput is one request per cycle with no bubbles.
- No response backpressure. The consumer must take rsp_* in the valid cycle.
- Offset = req_addr - BASE_ADDR, computed with 32-bit wrap. Word index = offset[ADDR_BITS+1:2]; lane = offset[1:0].
- Error conditions (any one sets rsp_err=1, blocks the write, and forces rdata=0):
  - offset >= 4*DEPTH_WORDS (this also covers addresses below BASE_ADDR through wrap);
  - half with lane[0]=1;
  - word with lane != 0;
  - size == 11.
- Store, with per-byte write enables on the word:
  - byte: wdata[7:0] goes to lane L, enable bit L only;
  - half: wdata[15:0] goes to lanes L, L+1;
  - word: all 4 lanes.
  - Other bytes of the word are unchanged (read-modify-write is not allowed; byte enables only).
- Load:
  - the addressed word is read at edge T;
  - the selected lane is extracted, then extended according to req_unsigned;
  - the result is registered into rsp_rdata.
- Store at T followed by a load of the same word at T+1 returns the newly written data. Write-then-read ordering is guaranteed by edge order.
- Requests presented while req_ready=0 are ignored, with no side effect.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum {INIT, RUN};
  - default BASE_ADDR constant.
- Sub-module dmem_lane_align, purely combinational:
  - store path: (size, lane, wdata) -> 4-bit byte enable and 32-bit lane-replicated data;
  - load path: (size, lane, unsigned, word) -> extended 32-bit result.
- The top level holds the array, the clear FSM, error decode, and the response registers.

Test Plan:
- Assert rst for 2 cycles, release. Then: init_busy=1 for exactly 256 cycles, req_ready rises on cycle 257, and loading any word returns 0.
- Store word 0xDEADBEEF @0x10010004; then lb @0x10010007 -> 0xFFFFFFDE; lbu same address -> 0x000000DE; lh @0x10010004 -> 0xFFFFBEEF; lhu @0x10010006 -> 0x0000DEAD.
- sb 0x12 @0x10010005 over 0xDEADBEEF; then lw @0x10010004 -> 0xDEAD12EF. Also check that no other word changed.
- lw @0x10010002 -> rsp_err=1, rdata=0. sh @0x10010001 -> err, word unchanged. Loads @0x1000FFFC and @0x10010400 -> err. size=11 -> err.
- Back-to-back requests sw 0x11223344 @0x10010010 then lw same address, on consecutive cycles -> rsp_valid on 2 consecutive cycles, second rdata=0x11223344. dbg_word0 tracks any store to 0x10010000.
- Assert rst at INIT cycle 100 and at a RUN cycle with a load in flight -> rsp_valid=0 immediately, and the clear restarts from word 0 (full 256-cycle INIT).
